// File: rtl/sdp_ram_be.sv
// Simple-dual-port RAM with a byte-enabled write port, an independent read port,
// configurable read latency and read-during-write policy, and a built-in clear sequencer.
module sdp_ram_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int DEPTH          = 32,
  parameter int RD_LATENCY     = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    clr_req,
  output logic                    busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic                    s1_valid;
  logic                    idle;
  logic                    wr_hit;
  logic                    rd_acc;
  logic                    rd_in_range;
  logic                    clr_wr;

  assign idle        = (state == IDLE);
  assign wr_hit      = idle && !rst && wr_en && ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_acc      = idle && rd_en;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
  assign clr_wr      = (state == CLEAR) && !rst;
  assign busy        = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The clear sequencer shares the single write port; user writes only land in IDLE.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_cnt] <= '0;
    end else if (wr_hit) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if ((WRITE_FIRST != 0) && wr_hit && (wr_addr == rd_addr)) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (wr_be[i]) begin
            rd_word[8*i +: 8] = wr_data[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_valid;

      // Extra output stage; data only advances with a valid read so rd_data holds otherwise.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign rd_data  = s2_data;
      assign rd_valid = s2_valid;
    end else begin : g_lat1
      assign rd_data  = s1_data;
      assign rd_valid = s1_valid;
    end
  endgenerate

endmodule

// File: doc/sdp_ram_be.md
Name: sdp_ram_be

Overview:
Parametrised simple-dual-port RAM, the successor to our single-port RAM. It has one write port with byte enables and one independent read port. Read latency, read-during-write policy and address range are configurable. A built-in clear sequencer zeroes the array after reset or on request, with busy reported throughout. It serves as the generic scratch/buffer memory for datapath blocks.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 5, address port width.
DEPTH, 32, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
RD_LATENCY, 1, cycles from rd_en to rd_data/rd_valid; legal values 1 or 2.
WRITE_FIRST, 0, read-during-write to the same address: 1 returns new data, 0 returns old data.
CLEAR_ON_RESET, 1, 1 starts the clear sequence automatically out of reset.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
wr_en  input  1  write request.
wr_addr  input  ADDR_WIDTH  write address.
wr_data  input  DATA_WIDTH  write data.
wr_be  input  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
rd_en  input  1  read request.
rd_addr  input  ADDR_WIDTH  read address.
rd_data  output  DATA_WIDTH  read data, registered.
rd_valid  output  1  one-cycle pulse marking rd_data valid.
clr_req  input  1  request a full-array clear (single-cycle pulse).
busy  output  1  high while the clear sequencer runs.

Behaviour:
- Reset (async assert):
  - rd_data=0, rd_valid=0, read pipeline flushed.
  - Clear counter=0.
  - State=CLEAR if CLEAR_ON_RESET=1 (busy=1), else IDLE (busy=0).
  - Array contents are not reset.
- FSM IDLE:
  - clr_req=1 -> CLEAR with counter=0; busy goes high the next cycle.
  - Normal read/write accepted in the same cycle as clr_req.
- FSM CLEAR:
  - Each cycle writes 0 to word[counter], then counter+1.
  - At counter=DEPTH-1 the write completes and the FSM returns to IDLE; busy drops the following cycle.
  - Duration is exactly DEPTH cycles.
  - clr_req is ignored. wr_en and rd_en are ignored (no write, no rd_valid).
- Write (IDLE only):
  - wr_en=1 and wr_addr<DEPTH: each byte with wr_be[i]=1 is updated at the clock edge; other bytes are unchanged.
  - wr_be=0 is a no-op.
- Read (IDLE only):
  - rd_en sampled at edge N.
  - RD_LATENCY=1: rd_data/rd_valid updated at edge N+1.
  - RD_LATENCY=2: one extra register stage; output at edge N+2.
  - Back-to-back reads give one result per cycle.
- rd_valid and rd_data hold:
  - rd_valid pulses one cycle per accepted read.
  - rd_data holds the last read value when no read completes.
- Out of range (addr >= DEPTH):
  - Write is silently dropped.
  - Read returns 0 with rd_valid=1.
- Read-during-write, same address, same cycle:
  - WRITE_FIRST=1: rd_data = old word with the enabled bytes replaced by wr_data.
  - WRITE_FIRST=0: rd_data = old word.
  - Different addresses: no interaction.
- Reads in flight when CLEAR starts still complete with their original data and rd_valid.
- Reset mid-clear:
  - Sequence restarts from word 0 if CLEAR_ON_RESET=1; otherwise the FSM goes to IDLE.
  - The partially cleared array is undefined to software.
- Synthesis: array maps to inferred block RAM. There is no tristate output; rd_data is always driven.

Test Plan:
- Reset, CLEAR_ON_RESET=1, DEPTH=32 -> busy=1 for 32 cycles after rst deasserts, then 0. Read of every address returns 0x00000000 with rd_valid 1 cycle later.
- Write addr 3 data 0xAABBCCDD be=4'b1111, then addr 3 data 0x11223344 be=4'b0101 -> read addr 3 = 0xAA22CC44.
- Same-cycle write addr 7 0xDEADBEEF (be=1111) and read addr 7, old value 0x0 -> rd_data=0xDEADBEEF if WRITE_FIRST=1, 0x00000000 if WRITE_FIRST=0.
- RD_LATENCY=2: rd_en on 4 consecutive cycles, addrs 0..3 holding 10,11,12,13 -> rd_valid high 4 consecutive cycles starting 2 cycles after the first rd_en, data 10,11,12,13 in order.
- ADDR_WIDTH=6, DEPTH=40: write 0x55 to addr 45 -> no effect on any word; read addr 45 -> 0 with rd_valid=1.
- clr_req during IDLE, then rst at clear cycle 10, CLEAR_ON_RESET=0 -> busy=0 immediately, rd_valid=0, FSM IDLE. Writes issued during the earlier CLEAR are dropped.
